// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its surroundings: control inputs, the
// external adder operands and sum, and the fetch-side outputs.
interface pc_sequencer_if;
  logic               EN;
  logic               BR_TAKEN;
  logic signed [15:0] BR_OFFSET;
  logic               JMP;
  logic        [15:0] JMP_TARGET;
  logic               HALT_REQ;
  logic               RESUME;
  logic        [15:0] ADD_A;
  logic        [15:0] ADD_B;
  logic        [15:0] ADD_R;
  logic        [15:0] PC;
  logic        [15:0] LINK;
  logic               FETCH_VALID;
  logic               HALTED;
  logic               MISALIGN;

  modport master (
    output EN, BR_TAKEN, BR_OFFSET, JMP, JMP_TARGET, HALT_REQ, RESUME, ADD_R,
    input  ADD_A, ADD_B, PC, LINK, FETCH_VALID, HALTED, MISALIGN
  );

  modport slave (
    input  EN, BR_TAKEN, BR_OFFSET, JMP, JMP_TARGET, HALT_REQ, RESUME, ADD_R,
    output ADD_A, ADD_B, PC, LINK, FETCH_VALID, HALTED, MISALIGN
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the shared 16-bit adder with PC and an
// increment or branch offset, and selects the next PC among halt/jump/branch/advance.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] INC          = 16'd2
) (
  input logic           CLK,
  input logic           RST_N,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t      state_p0, state_nxt;
  logic [15:0] pc_p0, pc_nxt;
  logic [15:0] link_p0, link_nxt;
  logic        misalign_p0, misalign_nxt;
  logic        fetch_valid_p0, halted_p0;

  function automatic logic [15:0] force_even(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

  // Operand mux feeds the external adder in every state.
  assign bus.ADD_A = pc_p0;
  assign bus.ADD_B = bus.BR_TAKEN ? bus.BR_OFFSET : INC;

  always_comb begin
    state_nxt    = state_p0;
    pc_nxt       = pc_p0;
    link_nxt     = link_p0;
    misalign_nxt = misalign_p0;
    case (state_p0)
      S_BOOT: state_nxt = S_RUN;
      S_RUN: begin
        if (bus.HALT_REQ) begin
          state_nxt = S_HALT;
        end else if (bus.JMP) begin
          pc_nxt = force_even(bus.JMP_TARGET);
          // With a concurrent branch the adder carries the offset, so the link is formed locally.
          link_nxt = bus.BR_TAKEN ? pc_p0 + INC : bus.ADD_R;
          if (bus.JMP_TARGET[0]) misalign_nxt = 1'b1;
        end else if (bus.BR_TAKEN) begin
          pc_nxt = force_even(bus.ADD_R);
          if (bus.ADD_R[0]) misalign_nxt = 1'b1;
        end else if (bus.EN) begin
          pc_nxt = bus.ADD_R;
        end
      end
      S_HALT: if (bus.RESUME) state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  // Register stage: architectural state and registered status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_p0       <= S_BOOT;
      pc_p0          <= RESET_VECTOR;
      link_p0        <= 16'h0000;
      misalign_p0    <= 1'b0;
      fetch_valid_p0 <= 1'b0;
      halted_p0      <= 1'b0;
    end else begin
      state_p0       <= state_nxt;
      pc_p0          <= pc_nxt;
      link_p0        <= link_nxt;
      misalign_p0    <= misalign_nxt;
      fetch_valid_p0 <= (state_nxt == S_RUN);
      halted_p0      <= (state_nxt == S_HALT);
    end
  end

  assign bus.PC          = pc_p0;
  assign bus.LINK        = link_p0;
  assign bus.MISALIGN    = misalign_p0;
  assign bus.FETCH_VALID = fetch_valid_p0;
  assign bus.HALTED      = halted_p0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural model of the external adder.
module tb_pc_sequencer;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(16'h0000), .INC(16'd2)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  assign bus.ADD_R = bus.ADD_A + bus.ADD_B;

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic jump_to(input logic [15:0] tgt);
    bus.JMP = 1'b1;
    bus.JMP_TARGET = tgt;
    step();
    bus.JMP = 1'b0;
  endtask

  initial begin
    bus.EN = 1'b0; bus.BR_TAKEN = 1'b0; bus.BR_OFFSET = 16'sd0;
    bus.JMP = 1'b0; bus.JMP_TARGET = 16'h0000;
    bus.HALT_REQ = 1'b0; bus.RESUME = 1'b0;

    // Reset state
    #3;
    chk("rst_pc", bus.PC, 16'h0000);
    chk("rst_link", bus.LINK, 16'h0000);
    chk("rst_fv", {15'd0, bus.FETCH_VALID}, 16'd0);
    chk("rst_halted", {15'd0, bus.HALTED}, 16'd0);
    chk("rst_mis", {15'd0, bus.MISALIGN}, 16'd0);

    // Release and sequential advance
    step();
    RST_N = 1'b1; bus.EN = 1'b1;
    step();
    chk("boot_pc", bus.PC, 16'h0000);
    chk("boot_fv", {15'd0, bus.FETCH_VALID}, 16'd1);
    chk("run_addb", bus.ADD_B, 16'h0002);
    step(); chk("seq_pc1", bus.PC, 16'h0002);
    step(); chk("seq_pc2", bus.PC, 16'h0004);
    step(); chk("seq_pc3", bus.PC, 16'h0006);

    // Jump ignores EN=0, link takes adder sum
    bus.EN = 1'b0;
    jump_to(16'h0010);
    chk("jmp_pc", bus.PC, 16'h0010);
    chk("jmp_link", bus.LINK, 16'h0008);

    // Stall then backward branch with EN=0
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_pc", bus.PC, 16'h0010);
    end
    bus.BR_TAKEN = 1'b1; bus.BR_OFFSET = 16'shFFF8;
    #1;
    chk("br_adda", bus.ADD_A, 16'h0010);
    chk("br_addb", bus.ADD_B, 16'hFFF8);
    step();
    bus.BR_TAKEN = 1'b0;
    chk("br_pc", bus.PC, 16'h0008);
    chk("br_mis", {15'd0, bus.MISALIGN}, 16'd0);

    // Jump wins over branch, link computed locally, misaligned target
    jump_to(16'h0020);
    chk("j20_pc", bus.PC, 16'h0020);
    bus.JMP = 1'b1; bus.JMP_TARGET = 16'h1235;
    bus.BR_TAKEN = 1'b1; bus.BR_OFFSET = 16'sh0100;
    step();
    bus.JMP = 1'b0; bus.BR_TAKEN = 1'b0;
    chk("jb_pc", bus.PC, 16'h1234);
    chk("jb_link", bus.LINK, 16'h0022);
    chk("jb_mis", {15'd0, bus.MISALIGN}, 16'd1);
    step();
    chk("mis_sticky", {15'd0, bus.MISALIGN}, 16'd1);

    // Mid-cycle reset clears sticky flag immediately
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst2_pc", bus.PC, 16'h0000);
    chk("rst2_mis", {15'd0, bus.MISALIGN}, 16'd0);
    chk("rst2_link", bus.LINK, 16'h0000);
    step();
    RST_N = 1'b1;
    step();

    // Wrap at top of address space
    jump_to(16'hFFFE);
    chk("wrap_pre", bus.PC, 16'hFFFE);
    bus.EN = 1'b1;
    step();
    bus.EN = 1'b0;
    chk("wrap_pc", bus.PC, 16'h0000);
    chk("wrap_mis", {15'd0, bus.MISALIGN}, 16'd0);

    // Halt beats jump; jumps ignored while halted; resume
    jump_to(16'h0040);
    bus.HALT_REQ = 1'b1; bus.JMP = 1'b1; bus.JMP_TARGET = 16'h0200; bus.EN = 1'b1;
    step();
    bus.HALT_REQ = 1'b0;
    chk("halt_pc", bus.PC, 16'h0040);
    chk("halt_flag", {15'd0, bus.HALTED}, 16'd1);
    chk("halt_fv", {15'd0, bus.FETCH_VALID}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("halt_hold", bus.PC, 16'h0040);
    end
    bus.JMP = 1'b0; bus.RESUME = 1'b1;
    step();
    bus.RESUME = 1'b0;
    chk("res_pc", bus.PC, 16'h0040);
    chk("res_halted", {15'd0, bus.HALTED}, 16'd0);
    chk("res_fv", {15'd0, bus.FETCH_VALID}, 16'd1);
    step();
    chk("res_adv", bus.PC, 16'h0042);

    // Odd branch sum: taken even, flag set
    bus.EN = 1'b0; bus.BR_TAKEN = 1'b1; bus.BR_OFFSET = 16'sh0003;
    step();
    bus.BR_TAKEN = 1'b0;
    chk("obr_pc", bus.PC, 16'h0044);
    chk("obr_mis", {15'd0, bus.MISALIGN}, 16'd1);

    // Asynchronous reset while halted
    jump_to(16'h0100);
    bus.HALT_REQ = 1'b1;
    step();
    bus.HALT_REQ = 1'b0;
    chk("h100_pc", bus.PC, 16'h0100);
    chk("h100_halted", {15'd0, bus.HALTED}, 16'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_pc", bus.PC, 16'h0000);
    chk("arst_halted", {15'd0, bus.HALTED}, 16'd0);
    chk("arst_fv", {15'd0, bus.FETCH_VALID}, 16'd0);
    chk("arst_link", bus.LINK, 16'h0000);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the 16-bit datapath. Holds the architectural PC and drives the operands of the external 16-bit adder (PC plus increment, or PC plus branch offset). It consumes the adder's sum to form the next PC. It also arbitrates jumps, branches, stalls and halt, and presents a registered link value and a fetch-valid strobe to the fetch stage.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset (must be even)
INC, 16'd2, sequential increment in bytes (one instruction word)

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
EN  input  1  advance enable; 0 = stall, PC holds
BR_TAKEN  input  1  branch resolved taken this cycle
BR_OFFSET  input  16  signed byte offset, already sign-extended, relative to current PC
JMP  input  1  absolute jump this cycle
JMP_TARGET  input  16  absolute jump address
HALT_REQ  input  1  enter halted state
RESUME  input  1  leave halted state
ADD_A  output  16  adder operand A (combinational)
ADD_B  output  16  adder operand B (combinational)
ADD_R  input  16  adder sum, ADD_A+ADD_B mod 2^16, combinational from the external adder
PC  output  16  current PC (registered)
LINK  output  16  PC+INC captured on the last taken jump (registered)
FETCH_VALID  output  1  PC holds a fetchable address this cycle (registered)
HALTED  output  1  sequencer halted (registered)
MISALIGN  output  1  sticky: a jump or branch target had bit 0 set

Behaviour:
- Reset (RST_N=0, async): PC=RESET_VECTOR, LINK=0, FETCH_VALID=0, HALTED=0, MISALIGN=0, state=BOOT. Deassertion takes effect on the next rising CLK.
- States: BOOT, RUN, HALT.
  - BOOT: one cycle after reset release, PC unchanged. FETCH_VALID goes to 1 and the state moves to RUN at the next edge.
  - RUN: normal sequencing.
  - HALT: PC frozen, FETCH_VALID=0, HALTED=1. Leaves on RESUME=1, returning to RUN with FETCH_VALID=1 on the next edge. JMP, BR_TAKEN and EN are ignored while in HALT.
- Operand mux (combinational, every state): ADD_A=PC; ADD_B=BR_OFFSET when BR_TAKEN=1, else INC. ADD_R is trusted as the 16-bit wrapped sum. No carry is exposed and overflow wraps (16'hFFFE+2 -> 16'h0000).
- Next-PC priority in RUN, evaluated at each rising edge:
  1. HALT_REQ=1: state goes to HALT and PC holds. Takes precedence over everything, including a simultaneous JMP or branch.
  2. JMP=1: PC <= {JMP_TARGET[15:1],1'b0}; LINK <= ADD_R. ADD_B is INC here unless BR_TAKEN is also 1; if both JMP and BR_TAKEN are set, JMP wins and LINK <= PC+INC, computed internally, never from ADD_R.
  3. BR_TAKEN=1: PC <= {ADD_R[15:1],1'b0}.
  4. EN=1: PC <= ADD_R.
  5. Otherwise: PC holds (stall).
- JMP and BR_TAKEN act regardless of EN. Redirects cannot be dropped by a stall.
- MISALIGN is set when an accepted JMP has JMP_TARGET[0]=1, or an accepted branch has ADD_R[0]=1. It clears only on reset. The target is still taken with bit 0 forced to 0.
- FETCH_VALID=1 in RUN, 0 in BOOT and HALT.
- Latency: a redirect presented in cycle N gives the new PC visible in cycle N+1. There are no bubbles inserted by this block.
- Reset mid-operation immediately restores reset values, including mid-HALT or during a stall.

Test Plan:
- Reset release, EN=1 for 4 cycles: PC 0000 in BOOT, then 0000, 0002, 0004, 0006 with FETCH_VALID=1 from cycle 2.
- PC=0010, EN=0 for 3 cycles, then BR_TAKEN=1 with BR_OFFSET=FFF8 and EN=0: PC holds 0010, then becomes 0008. ADD_B=FFF8 during the branch cycle.
- PC=0020, JMP=1, JMP_TARGET=1235, BR_TAKEN=1 in the same cycle: PC=1234, LINK=0022, MISALIGN=1.
- PC=FFFE, EN=1: PC wraps to 0000 with no error flag.
- PC=0040, HALT_REQ=1 with JMP=1: HALTED=1, PC stays 0040, FETCH_VALID=0. Three cycles later RESUME=1 gives RUN with PC=0040, then 0042 with EN=1.
- RST_N pulsed low mid-cycle while halted at PC=0100: PC=RESET_VECTOR and HALTED=0 immediately, without waiting for a CLK edge.
